// File: rtl/rl02_pkg.sv
// Shared definitions for the RL02 field/CRC datapath: sequencer state encoding,
// default widths and the field lengths used by the sector-level sequencer.
package rl02_pkg;

    localparam int WORD_W_DEF = 16;
    localparam int CRC_W_DEF  = 16;

    // Field lengths in words, consumed by the upstream sector sequencer.
    localparam int HDR_WORDS  = 2;
    localparam int DATA_WORDS = 128;

    typedef logic [2:0] seq_state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_GEN   = 3'd4;
    localparam logic [2:0] ST_CHECK = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

    function automatic logic is_busy(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/rl02_word_shifter.sv
// LSB-first load/shift register with a bit counter; wrap_o flags the last bit
// position of a word. Used for both the payload words and the serialised CRC.
module rl02_word_shifter #(
    parameter int WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       load_i,
    input  logic [WIDTH-1:0]           data_i,
    input  logic                       shift_i,
    input  logic                       cnt_clr_i,
    input  logic                       cnt_inc_i,
    output logic [WIDTH-1:0]           sreg_o,
    output logic [$clog2(WIDTH)-1:0]   cnt_o,
    output logic                       wrap_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over shift so a back-to-back reload lands on the wrap cycle.
    always_comb begin
        sreg_d = sreg_q;
        if (load_i) begin
            sreg_d = data_i;
        end else if (shift_i) begin
            sreg_d = sreg_q >> 1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_inc_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sreg_o = sreg_q;
    assign cnt_o  = cnt_q;
    assign wrap_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/rl02_crc_seq.sv
// Sequencer for one RL02 header/data field: feeds payload words bit-serially into
// the external CRC-16 engine, then either streams the CRC or checks a received one.
module rl02_crc_seq
    import rl02_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int CRC_W  = CRC_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_last,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              crc_clr,
    output logic              crc_en,
    output logic              crc_bit,
    input  logic [CRC_W-1:0]  crc_val,
    output logic              bit_out,
    output logic              bit_valid,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              crc_err
);

    localparam int CNT_W = $clog2(WORD_W);

    seq_state_t state_q, state_d;
    logic       mode_q, mode_d;
    logic       last_q, last_d;
    logic       ok_q, ok_d;
    logic       err_q, err_d;

    logic              sh_load;
    logic [WORD_W-1:0] sh_data;
    logic              sh_shift;
    logic              sh_clr;
    logic              sh_inc;
    logic [WORD_W-1:0] sreg;
    logic [CNT_W-1:0]  cnt;
    logic              wrap;

    logic handshake;
    logic gen_first;

    rl02_word_shifter #(
        .WIDTH(WORD_W)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (sh_load),
        .data_i   (sh_data),
        .shift_i  (sh_shift),
        .cnt_clr_i(sh_clr),
        .cnt_inc_i(sh_inc),
        .sreg_o   (sreg),
        .cnt_o    (cnt),
        .wrap_o   (wrap)
    );

    always_comb begin
        word_ready = 1'b0;
        case (state_q)
            ST_WAIT:  word_ready = 1'b1;
            ST_SHIFT: word_ready = wrap && !last_q;
            ST_CHECK: word_ready = 1'b1;
            default:  word_ready = 1'b0;
        endcase
    end

    assign handshake = word_valid && word_ready;
    // First GEN cycle: the engine result is only now final, so its bit 0 goes out directly.
    assign gen_first = (state_q == ST_GEN) && (cnt == '0);

    // start is honoured in every state and restarts the field from CLEAR.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        last_d   = last_q;
        ok_d     = ok_q;
        err_d    = err_q;
        sh_load  = 1'b0;
        sh_data  = '0;
        sh_shift = 1'b0;
        sh_clr   = 1'b0;
        sh_inc   = 1'b0;

        if (start) begin
            state_d = ST_CLEAR;
            mode_d  = mode;
            last_d  = 1'b0;
            ok_d    = 1'b0;
            err_d   = 1'b0;
            sh_load = 1'b1;
            sh_clr  = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_CLEAR: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (handshake) begin
                        sh_load = 1'b1;
                        sh_data = word_in;
                        sh_clr  = 1'b1;
                        last_d  = word_last;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    sh_shift = 1'b1;
                    sh_inc   = 1'b1;
                    if (wrap) begin
                        if (last_q) begin
                            state_d = mode_q ? ST_GEN : ST_CHECK;
                        end else if (handshake) begin
                            sh_load = 1'b1;
                            sh_data = word_in;
                            last_d  = word_last;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_GEN: begin
                    sh_inc = 1'b1;
                    if (gen_first) begin
                        sh_load = 1'b1;
                        sh_data = WORD_W'(crc_val >> 1);
                    end else begin
                        sh_shift = 1'b1;
                    end
                    if (wrap) begin
                        state_d = ST_DONE;
                    end
                end
                ST_CHECK: begin
                    if (handshake) begin
                        ok_d    = (CRC_W'(word_in) == crc_val);
                        err_d   = (CRC_W'(word_in) != crc_val);
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            last_q  <= last_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    assign crc_clr   = (state_q == ST_CLEAR);
    assign crc_en    = (state_q == ST_SHIFT);
    assign crc_bit   = crc_en && sreg[0];
    assign bit_valid = mode_q && ((state_q == ST_SHIFT) || (state_q == ST_GEN));
    assign bit_out   = bit_valid && (gen_first ? crc_val[0] : sreg[0]);
    assign busy      = is_busy(state_q);
    assign done      = (state_q == ST_DONE);
    assign crc_ok    = ok_q;
    assign crc_err   = err_q;

endmodule

// File: tb/tb_rl02_crc_seq.sv
// Scoreboard bench for rl02_crc_seq with a behavioural serial CRC-16 engine
// (reflected 0x8005, zero init) standing in for the team engine.
module tb_rl02_crc_seq;

    localparam int WW = 16;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic [WW-1:0] word_in = '0;
    logic          word_last = 1'b0;
    logic          word_valid = 1'b0;
    logic          word_ready, crc_clr, crc_en, crc_bit;
    logic [CW-1:0] crc_val;
    logic          bit_out, bit_valid, busy, done, crc_ok, crc_err;

    int checks = 0;
    int errors = 0;

    // Scoreboard queues: serial bits in order, and {crc_ok, crc_err} per field.
    logic       expBits[$];
    logic [1:0] expRes[$];
    logic [1:0] monRes;
    logic       monBit;

    // Monitor-side tracking, reset at each field start.
    int          cyc = 0;
    int          fieldStart, firstBit, lastBitCyc, bitCount, maxGap, doneCyc;
    int          readyCount, lastReadyCyc;
    logic        readyBad;
    logic [15:0] lastBits;
    logic [15:0] modelCrc;
    logic [15:0] vec[0:127];

    always #5 clk = ~clk;

    rl02_crc_seq #(
        .WORD_W(WW),
        .CRC_W (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .word_in   (word_in),
        .word_last (word_last),
        .word_valid(word_valid),
        .word_ready(word_ready),
        .crc_clr   (crc_clr),
        .crc_en    (crc_en),
        .crc_bit   (crc_bit),
        .crc_val   (crc_val),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .busy      (busy),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err)
    );

    function automatic logic [15:0] crcStep(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[0] ^ b;
        return (c >> 1) ^ (fb ? 16'hA001 : 16'h0000);
    endfunction

    function automatic logic [15:0] crcWord(input logic [15:0] c, input logic [15:0] w);
        logic [15:0] r;
        r = c;
        for (int k = 0; k < 16; k++) r = crcStep(r, w[k]);
        return r;
    endfunction

    function automatic logic [9:0] outVec();
        return {word_ready, crc_clr, crc_en, crc_bit, bit_out, bit_valid, busy, done, crc_ok, crc_err};
    endfunction

    // Serial engine model: registers on the edge that consumes each bit.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_val <= '0;
        else if (crc_clr) crc_val <= '0;
        else if (crc_en) crc_val <= crcStep(crc_val, crc_bit);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic resetTrack();
        fieldStart   = cyc;
        firstBit     = -1;
        lastBitCyc   = -1;
        bitCount     = 0;
        maxGap       = 0;
        doneCyc      = -1;
        readyCount   = 0;
        lastReadyCyc = -1;
        readyBad     = 1'b0;
        lastBits     = '0;
        modelCrc     = '0;
    endtask

    // Monitor: samples 2 ns after each rising edge, pops the scoreboard on outputs.
    always @(posedge clk) begin
        #2;
        cyc++;
        if (bit_valid) begin
            if (expBits.size() == 0) begin
                checkOutput("bit_unexpected", 32'd1, 32'd0);
            end else begin
                monBit = expBits.pop_front();
                checkOutput("bit_out", {31'd0, bit_out}, {31'd0, monBit});
            end
            if (firstBit < 0) firstBit = cyc;
            else if (cyc - lastBitCyc - 1 > maxGap) maxGap = cyc - lastBitCyc - 1;
            lastBitCyc = cyc;
            bitCount++;
            lastBits = {bit_out, lastBits[15:1]};
        end
        if (word_ready) begin
            readyCount++;
            if (lastReadyCyc >= 0 && cyc - lastReadyCyc != 16) readyBad = 1'b1;
            lastReadyCyc = cyc;
        end
        if (done) begin
            doneCyc = cyc;
            if (expRes.size() == 0) begin
                checkOutput("done_unexpected", 32'd1, 32'd0);
            end else begin
                monRes = expRes.pop_front();
                checkOutput("crc_flags", {30'd0, crc_ok, crc_err}, {30'd0, monRes});
            end
        end
    end

    task automatic startField(input logic m);
        @(negedge clk);
        start      = 1'b1;
        mode       = m;
        word_valid = 1'b0;
        resetTrack();
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
    endtask

    // Presents one payload word and returns at the negedge after its handshake.
    task automatic applyStimulus(input logic [15:0] w, input logic last, input logic m);
        int t;
        t = 0;
        word_in    = w;
        word_last  = last;
        word_valid = 1'b1;
        while (!word_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) checkOutput("ready_timeout", 32'd1, 32'd0);
        if (m) for (int k = 0; k < 16; k++) expBits.push_back(w[k]);
        modelCrc = crcWord(modelCrc, w);
        @(negedge clk);
        word_valid = 1'b0;
    endtask

    task automatic finishField(input logic m, input logic [15:0] chkXor);
        int t;
        if (m) begin
            for (int k = 0; k < 16; k++) expBits.push_back(modelCrc[k]);
            expRes.push_back(2'b00);
        end else begin
            expRes.push_back((chkXor == 16'h0000) ? 2'b10 : 2'b01);
            applyStimulus(modelCrc ^ chkXor, 1'b0, 1'b0);
        end
        t = 0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) checkOutput("done_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) vec[i] = 16'($urandom);
        resetTrack();

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs", {22'd0, outVec()}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_outputs", {22'd0, outVec()}, 32'd0);

        $display("[TB] generate, single zero word");
        startField(1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b1);
        finishField(1'b1, 16'h0000);
        checkOutput("t1_first_bit", firstBit - fieldStart, 3);
        checkOutput("t1_bit_count", bitCount, 32);
        checkOutput("t1_done_cycle", doneCyc - fieldStart, 35);
        checkOutput("t1_crc_bits", {16'd0, lastBits}, 32'h0000);

        $display("[TB] check, zero word with matching CRC");
        startField(1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        finishField(1'b0, 16'h0000);
        checkOutput("t2_no_bits", bitCount, 0);
        checkOutput("t2_done_cycle", doneCyc - fieldStart, 20);
        repeat (3) @(negedge clk);
        checkOutput("t2_ok_held", {30'd0, crc_ok, crc_err}, 32'd2);

        $display("[TB] check, zero word with CRC word 0x0001");
        startField(1'b0);
        checkOutput("t2_flags_cleared", {30'd0, crc_ok, crc_err}, 32'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0);
        finishField(1'b0, 16'h0001);
        repeat (2) @(negedge clk);
        checkOutput("t2_err_held", {30'd0, crc_ok, crc_err}, 32'd1);

        $display("[TB] back-to-back 128 words");
        startField(1'b1);
        for (int i = 0; i < 128; i++) applyStimulus(vec[i], i == 127, 1'b1);
        finishField(1'b1, 16'h0000);
        checkOutput("t3_bit_count", bitCount, 2064);
        checkOutput("t3_max_gap", maxGap, 0);
        checkOutput("t3_first_bit", firstBit - fieldStart, 3);
        checkOutput("t3_done_cycle", doneCyc - fieldStart, 3 + 2064);
        checkOutput("t3_ready_count", readyCount, 128);
        checkOutput("t3_ready_spacing", {31'd0, readyBad}, 32'd0);
        checkOutput("t3_crc_bits", {16'd0, lastBits}, {16'd0, modelCrc});

        $display("[TB] stall between words");
        startField(1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vec[i], i == 3, 1'b1);
            if (i == 1) repeat (21) @(negedge clk);
        end
        finishField(1'b1, 16'h0000);
        checkOutput("t4_gap", maxGap, 6);
        checkOutput("t4_bit_count", bitCount, 80);
        checkOutput("t4_done_cycle", doneCyc - fieldStart, 3 + 80 + 6);
        checkOutput("t4_crc_bits", {16'd0, lastBits}, {16'd0, modelCrc});

        $display("[TB] abort at bit 7 of word 2");
        startField(1'b1);
        applyStimulus(vec[10], 1'b0, 1'b1);
        applyStimulus(vec[11], 1'b0, 1'b1);
        repeat (7) @(negedge clk);
        start = 1'b1;
        mode  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 1'b0;
        checkOutput("t5_abort_clr", {31'd0, crc_clr}, 32'd1);
        checkOutput("t5_abort_bit_valid", {31'd0, bit_valid}, 32'd0);
        expBits.delete();
        resetTrack();
        fieldStart = cyc - 1;
        applyStimulus(vec[20], 1'b0, 1'b1);
        applyStimulus(vec[21], 1'b1, 1'b1);
        finishField(1'b1, 16'h0000);
        checkOutput("t5_done_cycle", doneCyc - fieldStart, 51);
        checkOutput("t5_crc_bits", {16'd0, lastBits}, {16'd0, modelCrc});

        $display("[TB] asynchronous reset mid-GEN");
        startField(1'b1);
        applyStimulus(vec[30], 1'b1, 1'b1);
        for (int k = 0; k < 16; k++) expBits.push_back(modelCrc[k]);
        expRes.push_back(2'b00);
        repeat (21) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_reset_outputs", {22'd0, outVec()}, 32'd0);
        expBits.delete();
        expRes.delete();
        @(negedge clk);
        rst_n = 1'b1;
        startField(1'b1);
        applyStimulus(vec[31], 1'b1, 1'b1);
        finishField(1'b1, 16'h0000);
        checkOutput("t6_done_cycle", doneCyc - fieldStart, 35);
        checkOutput("t6_crc_bits", {16'd0, lastBits}, {16'd0, modelCrc});
        checkOutput("t6_queue_drained", expBits.size() + expRes.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
